shift_add_mult_ctrl: RTL and testbench

SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

---
 rtl/shift_add_mult_ctrl_pkg.sv | 13 +
 rtl/shift_add_mult_ctrl_full_add_n_bit.sv | 25 ++
 rtl/shift_add_mult_ctrl.sv | 81 ++++++++
 tb/tb_shift_add_mult_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types for the shift-add multiplier controller.
// State encoding and default operand width.
package shift_add_mult_ctrl_pkg;

  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_full_add_n_bit.sv
// N-bit ripple-carry adder with carry in/out.
// Used as the single accumulator adder of the multiplier.
module full_add_n_bit #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c_in,
  output logic [N-1:0] o_sum,
  output logic         o_c_out
);

  logic [N:0] w_c;

  assign w_c[0] = i_c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i])
                     | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_c_out = w_c[N];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-add unsigned multiplier, one bit per cycle.
// IDLE -> RUN (N cycles) -> DONE (1 cycle) -> IDLE.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  logic [N-1:0]   r_mcand;
  logic [2*N-1:0] r_p;
  logic [CW-1:0]  r_count;

  logic [N-1:0]   w_addend;
  logic [N-1:0]   w_sum;
  logic           w_c;

  // Adding zero when P[0]=0 yields {0, P_hi} with no separate bypass path.
  assign w_addend = r_p[0] ? r_mcand : '0;

  full_add_n_bit #(
    .N(N)
  ) u_add (
    .i_a    (r_p[2*N-1:N]),
    .i_b    (w_addend),
    .i_c_in (1'b0),
    .o_sum  (w_sum),
    .o_c_out(w_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_mcand <= '0;
      r_p     <= '0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_p     <= {{N{1'b0}}, b};
            r_count <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_p     <= {w_c, w_sum, r_p[N-1:1]};
          r_count <= r_count + 1'b1;
          if (r_count == CW'(N - 1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready   = (r_state == ST_IDLE);
  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign product = r_p;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl at N=8 and N=4.
// Expected products queued on acceptance, compared on done.
module tb_shift_add_mult_ctrl;

  logic        clk;
  logic        rstn8, start8, ready8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        rstn4, start4, ready4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  int n_chk  = 0;
  int n_fail = 0;
  int ecnt   = 0;
  int n_done8 = 0;
  int n_done4 = 0;
  int prev_de8 = 0;
  int last_de8 = 0;

  logic [15:0] q8[$];
  int          qe8[$];
  logic [7:0]  q4[$];
  int          qe4[$];

  shift_add_mult_ctrl #(.N(8)) u_dut8 (
    .clk    (clk),
    .resetn (rstn8),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .ready  (ready8),
    .busy   (busy8),
    .done   (done8),
    .product(product8)
  );

  shift_add_mult_ctrl #(.N(4)) u_dut4 (
    .clk    (clk),
    .resetn (rstn4),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .ready  (ready4),
    .busy   (busy4),
    .done   (done4),
    .product(product4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon8
    logic [15:0] e;
    int ae;
    if (!rstn8) begin
      q8.delete();
      qe8.delete();
    end else begin
      if (done8) begin
        n_done8++;
        prev_de8 = last_de8;
        last_de8 = ecnt + 1;
        if (q8.size() == 0) begin
          chk("spur_done8", 32'(done8), 0);
        end else begin
          e  = q8.pop_front();
          ae = qe8.pop_front();
          chk("prod8", 32'(product8), 32'(e));
          chk("lat8", 32'(last_de8 - ae), 9);
        end
      end
      if (start8 && ready8) begin
        q8.push_back(16'(a8) * 16'(b8));
        qe8.push_back(ecnt + 1);
      end
    end
  end

  always @(negedge clk) begin : mon4
    logic [7:0] e;
    int ae;
    if (!rstn4) begin
      q4.delete();
      qe4.delete();
    end else begin
      if (done4) begin
        n_done4++;
        if (q4.size() == 0) begin
          chk("spur_done4", 32'(done4), 0);
        end else begin
          e  = q4.pop_front();
          ae = qe4.pop_front();
          chk("prod4", 32'(product4), 32'(e));
          chk("lat4", 32'(ecnt + 1 - ae), 5);
        end
      end
      if (start4 && ready4) begin
        q4.push_back(8'(a4) * 8'(b4));
        qe4.push_back(ecnt + 1);
      end
    end
  end

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    int t = 0;
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    while (!ready8 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 100) chk("op8_timeout", 32'(ready8), 1);
    @(posedge clk); #2;
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y);
    int t = 0;
    a4 = x;
    b4 = y;
    start4 = 1'b1;
    while (!ready4 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 100) chk("op4_timeout", 32'(ready4), 1);
    @(posedge clk); #2;
  endtask

  task automatic idle8();
    int t = 0;
    while ((q8.size() != 0 || !ready8) && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 200) chk("idle8_timeout", 32'(q8.size()), 0);
  endtask

  task automatic idle4();
    int t = 0;
    while ((q4.size() != 0 || !ready4) && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 200) chk("idle4_timeout", 32'(q4.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rstn8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    rstn4 = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0;
    #3;
    chk("rst_ready", 32'(ready8), 1);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_prod", 32'(product8), 0);
    chk("rst_prod4", 32'(product4), 0);
    @(posedge clk); #2;

    // first start with reset release must be taken on the next edge
    rstn8 = 1'b1;
    rstn4 = 1'b1;
    op8(8'd255, 8'd255);
    start8 = 1'b0;
    idle8();
    chk("ff_prod", 32'(product8), 32'hFE01);

    op8(8'd127, 8'd128); start8 = 1'b0; idle8();
    chk("p_3f80", 32'(product8), 16256);
    op8(8'd0, 8'd200); start8 = 1'b0; idle8();
    chk("p_a0", 32'(product8), 0);
    op8(8'd200, 8'd0); start8 = 1'b0; idle8();
    chk("p_b0", 32'(product8), 0);

    n0 = n_done8;
    op8(8'd3, 8'd5);
    start8 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (done8 || (busy8 && (k == 2 || k == 3))) begin
        start8 = 1'b1;
        a8 = 8'd9;
        b8 = 8'd9;
      end else begin
        start8 = 1'b0;
      end
      if (!busy8 && !done8) break;
    end
    start8 = 1'b0;
    idle8();
    chk("ign_prod", 32'(product8), 15);
    chk("ign_ndone", 32'(n_done8 - n0), 1);

    n0 = n_done8;
    op8(8'd200, 8'd100);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstn8 = 1'b0;
    #1;
    chk("abort_ready", 32'(ready8), 1);
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_prod", 32'(product8), 0);
    @(posedge clk); #2;
    rstn8 = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("abort_ndone", 32'(n_done8 - n0), 0);
    chk("abort_idle", 32'(ready8), 1);

    n0 = n_done8;
    op8(8'd17, 8'd19);
    op8(8'd255, 8'd1);
    start8 = 1'b0;
    idle8();
    chk("b2b_ndone", 32'(n_done8 - n0), 2);
    chk("b2b_gap", 32'(last_de8 - prev_de8), 10);
    chk("b2b_prod", 32'(product8), 255);

    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom));
    end
    start8 = 1'b0;
    idle8();

    op4(4'd15, 4'd15); start4 = 1'b0; idle4();
    chk("p4_max", 32'(product4), 225);
    for (int i = 0; i < 1000; i++) begin
      op4(4'($urandom), 4'($urandom));
    end
    start4 = 1'b0;
    idle4();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
